// File: rtl/sm_bus_arbiter.sv
// Round-robin arbiter: one registered one-hot grant at a time, released on ack,
// requester withdrawal or watchdog timeout, with an idle cycle between grants.
module sm_bus_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 16,
  localparam int IW     = (N > 1) ? $clog2(N) : 1,
  localparam int CW     = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          timeout,
  output logic          fsm_state
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Handshake: req[i] stays high while requester i wants the resource; a grant
  // is live while gnt[i]=1 and ends on the edge where ack=1 (or req[i] drops).
  state_t        state_q, state_n;
  logic [IW-1:0] ptr_q, ptr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [N-1:0]  gnt_n;
  logic [IW-1:0] gnt_id_n;
  logic          busy_n;
  logic          timeout_n;

  logic [IW-1:0] win;
  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] ptr_inc;
  logic          release_now;

  // Search from ptr upward with an explicit modulo-N wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  assign ptr_inc     = (gnt_id == IW'(N-1)) ? '0 : gnt_id + 1'b1;
  assign release_now = ack || !req[gnt_id] || (cnt_q == CW'(TIMEOUT-1));

  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    busy_n    = busy;
    timeout_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          gnt_id_n   = win;
          busy_n     = 1'b1;
          cnt_n      = '0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_n     = '0;
          busy_n    = 1'b0;
          ptr_n     = ptr_inc;
          state_n   = IDLE;
          // Only a pure watchdog expiry pulses; ack and withdrawal take priority.
          timeout_n = !ack && req[gnt_id];
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      gnt     <= gnt_n;
      gnt_id  <= gnt_id_n;
      busy    <= busy_n;
      timeout <= timeout_n;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_sm_bus_arbiter.sv
// Bench for sm_bus_arbiter (N=4, TIMEOUT=8): directed plan with literal
// expectations, then random traffic checked cycle by cycle against a model.
module tb_sm_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         ack;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;
  logic         fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];

  sm_bus_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .gnt(gnt), .gnt_id(gnt_id),
    .busy(busy), .timeout(timeout), .fsm_state(fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle; returns at the following negedge.
  task automatic drive(input logic [N-1:0] r, input logic a);
    req = r;
    ack = a;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, 1'b0);
    drive('0, 1'b0);
    rst = 1'b0;
  endtask

  // Behavioural model: who owns the resource and for how many cycles.
  bit     m_busy = 0;
  int     m_id   = 0;
  int     m_ptr  = 0;
  int     m_held = 0;
  bit     m_to   = 0;
  bit     prev_busy = 0;
  bit     prev_to   = 0;

  always @(posedge clk) begin
    logic [N-1:0] r;
    logic a, rs;
    r = req; a = ack; rs = rst;
    if (rs) begin
      m_busy = 0; m_id = 0; m_ptr = 0; m_held = 0; m_to = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!m_busy && r[c]) begin
          m_busy = 1; m_id = c; m_held = 1;
          exp_q.push_back(2'(c));
        end
      end
    end else begin
      m_to = 0;
      if (a || !r[m_id] || m_held == TO) begin
        m_busy = 0;
        m_ptr  = (m_id + 1) % N;
        m_to   = !a && r[m_id];
      end else begin
        m_held++;
      end
    end
    #1;
    chk("gnt",     int'(gnt),     m_busy ? (1 << m_id) : 0);
    chk("gnt_id",  int'(gnt_id),  m_id);
    chk("busy",    int'(busy),    int'(m_busy));
    chk("timeout", int'(timeout), int'(m_to));
    chk("state",   int'(fsm_state), int'(m_busy));
    chk("inv_onehot", int'($onehot0(gnt)), 1);
    chk("inv_busy_or", int'(busy), int'(|gnt));
    if (busy) chk("inv_id_bit", int'(gnt[gnt_id]), 1);
    if (timeout) begin
      chk("inv_to_twice", int'(prev_to), 0);
      chk("inv_to_idle", int'(busy), 0);
    end
    if (busy && !prev_busy) begin
      if (exp_q.size() == 0) chk("sb_grant_unexpected", int'(gnt_id), -1);
      else chk("sb_grant_id", int'(gnt_id), int'(exp_q.pop_front()));
    end
    prev_busy = busy;
    prev_to   = timeout;
  end

  int rr_seq[5];
  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    @(negedge clk);

    // Reset and single request
    do_reset();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
    drive(4'b0100, 1'b0);
    chk("single_gnt", int'(gnt), 4);
    chk("single_id", int'(gnt_id), 2);
    drive(4'b0100, 1'b1);
    chk("single_release", int'(gnt), 0);
    drive(4'b1101, 1'b0);
    chk("search_from_3", int'(gnt_id), 3);
    drive(4'b0000, 1'b0);

    // Round-robin with ack on the 2nd grant cycle
    do_reset();
    for (int g = 0; g < 5; g++) begin
      drive(4'b1111, 1'b0);
      rr_seq[g] = int'(gnt_id);
      drive(4'b1111, 1'b0);
      drive(4'b1111, 1'b1);
      chk("rr_gap", int'(gnt), 0);
    end
    for (int g = 0; g < 5; g++) chk("rr_order", rr_seq[g], exp_rr[g]);

    // Timeout: held exactly TO cycles
    do_reset();
    drive(4'b0010, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      drive(4'b0010, 1'b0);
      chk("to_hold", int'(busy), 1);
    end
    drive(4'b0010, 1'b0);
    chk("to_release", int'(gnt), 0);
    chk("to_pulse", int'(timeout), 1);
    drive(4'b0010, 1'b0);
    chk("to_regrant", int'(gnt), 2);
    chk("to_pulse_end", int'(timeout), 0);

    // Ack on the threshold cycle
    for (int i = 0; i < TO - 1; i++) drive(4'b0010, 1'b0);
    drive(4'b0010, 1'b1);
    chk("tie_release", int'(gnt), 0);
    chk("tie_no_timeout", int'(timeout), 0);

    // Withdrawal and wrap
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b1);
    drive(4'b0001, 1'b0);
    chk("wrap_gnt", int'(gnt), 1);
    drive(4'b0000, 1'b0);
    chk("withdraw_gnt", int'(gnt), 0);
    chk("withdraw_no_to", int'(timeout), 0);
    drive(4'b0011, 1'b0);
    chk("ptr_after_withdraw", int'(gnt_id), 1);
    drive(4'b0000, 1'b0);

    // Reset mid-grant
    drive(4'b1000, 1'b0);
    chk("mid_gnt_id", int'(gnt_id), 3);
    rst = 1'b1;
    drive(4'b1000, 1'b0);
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_id", int'(gnt_id), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_to", int'(timeout), 0);
    rst = 1'b0;
    drive(4'b1001, 1'b0);
    chk("post_rst_id", int'(gnt_id), 0);
    drive(4'b0000, 1'b0);

    // Random traffic: sticky requests, sparse ack, rare reset
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = req;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      rst = ($urandom_range(0, 199) == 0);
      drive(r, ($urandom_range(0, 11) == 0));
    end
    rst = 1'b0;
    drive('0, 1'b0);
    drive('0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
